// File: rtl/led_display_arbiter_if.sv
// Bus between the clock/alarm logic and the display arbiter.
// The master side (clock/alarm logic) drives digit sources and requests;
// the slave side (arbiter) returns handshake pulses and the digit codes
// that feed the LED scan unit.
interface led_display_arbiter_if;
    logic [31:0] time_digits;
    logic        edit_req;
    logic [31:0] edit_digits;
    logic [3:0]  edit_field;
    logic        edit_activity;
    logic        edit_done;
    logic        msg_req;
    logic [31:0] msg_digits;
    logic        msg_ack;
    logic        edit_abort;
    logic [7:0]  led1_out;
    logic [7:0]  led2_out;
    logic [7:0]  led3_out;
    logic [7:0]  led4_out;
    logic [1:0]  mode;

    modport master (
        output time_digits, edit_req, edit_digits, edit_field,
               edit_activity, edit_done, msg_req, msg_digits,
        input  msg_ack, edit_abort, led1_out, led2_out, led3_out,
               led4_out, mode
    );

    modport slave (
        input  time_digits, edit_req, edit_digits, edit_field,
               edit_activity, edit_done, msg_req, msg_digits,
        output msg_ack, edit_abort, led1_out, led2_out, led3_out,
               led4_out, mode
    );
endinterface

// File: rtl/led_display_arbiter.sv
// led_display_arbiter: chooses what the 4-digit display shows (live time,
// an edit session with a blinking field, or a held message), with message
// hold timing and an edit inactivity timeout.
// Optional build macro LEAD_ZERO_BLANK_EN: blank the leading hour zero
// (digit 1 equal to ZERO_SEG) while showing live time.
module led_display_arbiter #(
    parameter int         TICK_DIV     = 12500000,
    parameter int         MSG_TICKS    = 8,
    parameter int         EDIT_TIMEOUT = 40,
    parameter logic [7:0] ZERO_SEG     = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_display_arbiter_if.slave  bus
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(MSG_TICKS + 1);
    localparam int IW = $clog2(EDIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_TIME = 2'b00,
        ST_EDIT = 2'b01,
        ST_MSG  = 2'b10
    } state_t;

    state_t         state_q, state_d;
    state_t         ret_q, ret_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           blink_q, blink_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [31:0]    msg_q, msg_d;
    logic           ack_q, ack_d;
    logic           abort_q, abort_d;
    logic [1:0]     mode_q;
    logic [7:0]     led_q [4];
    logic [7:0]     led_d [4];

    logic           tick;
    logic           lead_blank_en;
    logic           lead_blank;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

`ifdef LEAD_ZERO_BLANK_EN
    assign lead_blank_en = 1'b1;
`else
    assign lead_blank_en = 1'b0;
`endif

    assign lead_blank = lead_blank_en && (bus.time_digits[7:0] == ZERO_SEG);

    // Next-state logic: tick generator, mode transitions, hold/idle counters.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        hold_cnt_d = hold_cnt_q;
        idle_cnt_d = idle_cnt_q;
        msg_d      = msg_q;
        ack_d      = 1'b0;
        abort_d    = 1'b0;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        blink_d    = tick ? ~blink_q : blink_q;

        case (state_q)
            ST_TIME: begin
                if (bus.msg_req) begin
                    msg_d      = bus.msg_digits;
                    ack_d      = 1'b1;
                    hold_cnt_d = '0;
                    ret_d      = ST_TIME;
                    state_d    = ST_MSG;
                end else if (bus.edit_req) begin
                    // Start the session with the edited field visible.
                    state_d    = ST_EDIT;
                    idle_cnt_d = '0;
                    tick_cnt_d = '0;
                    blink_d    = 1'b0;
                end
            end

            ST_MSG: begin
                if (bus.msg_req) begin
                    // A new message restarts the hold from zero.
                    msg_d      = bus.msg_digits;
                    ack_d      = 1'b1;
                    hold_cnt_d = '0;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HW'(MSG_TICKS - 1)) begin
                        // Only resume editing if the session is still wanted.
                        if (ret_q == ST_EDIT && bus.edit_req) begin
                            state_d = ST_EDIT;
                        end else begin
                            state_d = ST_TIME;
                        end
                    end
                end
            end

            ST_EDIT: begin
                if (bus.msg_req) begin
                    msg_d      = bus.msg_digits;
                    ack_d      = 1'b1;
                    hold_cnt_d = '0;
                    ret_d      = ST_EDIT;
                    state_d    = ST_MSG;
                end else if (bus.edit_done || !bus.edit_req) begin
                    state_d = ST_TIME;
                end else if (bus.edit_activity) begin
                    // Key press: restart inactivity and show the field solid.
                    idle_cnt_d = '0;
                    tick_cnt_d = '0;
                    blink_d    = 1'b0;
                end else if (tick) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_q == IW'(EDIT_TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                        state_d = ST_TIME;
                    end
                end
            end

            default: begin
                state_d = ST_TIME;
            end
        endcase
    end

    // Per-digit source selection, driven from the next state so the display
    // and mode change on the same edge as the state itself.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [7:0] time_seg;
            logic [7:0] edit_seg;

            assign time_seg = (gi == 0 && lead_blank) ? 8'h00
                                                      : bus.time_digits[gi*8 +: 8];
            assign edit_seg = (bus.edit_field[gi] && blink_d) ? 8'h00
                                                              : bus.edit_digits[gi*8 +: 8];

            // Select this digit's code for the state that will be active.
            always_comb begin
                led_d[gi] = 8'h00;
                case (state_d)
                    ST_TIME: led_d[gi] = time_seg;
                    ST_EDIT: led_d[gi] = edit_seg;
                    ST_MSG:  led_d[gi] = msg_d[gi*8 +: 8];
                    default: led_d[gi] = 8'h00;
                endcase
            end

            // Registered digit output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    led_q[gi] <= 8'h00;
                end else begin
                    led_q[gi] <= led_d[gi];
                end
            end
        end
    endgenerate

    // State, counters and handshake pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TIME;
            ret_q      <= ST_TIME;
            tick_cnt_q <= '0;
            blink_q    <= 1'b0;
            hold_cnt_q <= '0;
            idle_cnt_q <= '0;
            msg_q      <= '0;
            ack_q      <= 1'b0;
            abort_q    <= 1'b0;
            mode_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            tick_cnt_q <= tick_cnt_d;
            blink_q    <= blink_d;
            hold_cnt_q <= hold_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            msg_q      <= msg_d;
            ack_q      <= ack_d;
            abort_q    <= abort_d;
            mode_q     <= state_d;
        end
    end

    assign bus.msg_ack    = ack_q;
    assign bus.edit_abort = abort_q;
    assign bus.mode       = mode_q;
    assign bus.led1_out   = led_q[0];
    assign bus.led2_out   = led_q[1];
    assign bus.led3_out   = led_q[2];
    assign bus.led4_out   = led_q[3];

endmodule
